assert_ctrl_mux: RTL



---
 rtl/assert_ctrl_pkg.sv | 27 ++
 rtl/assert_ctrl_chan.sv | 63 ++++++
 rtl/assert_ctrl_mux.sv | 114 +++++++++++
 3 files changed

// File: rtl/assert_ctrl_pkg.sv
// Shared types and helpers for the assertion-control checker.
// Opcodes follow the $assertcontrol control_type numbering.
package assert_ctrl_pkg;

    typedef enum logic [3:0] {
        LOCK       = 4'd1,
        UNLOCK     = 4'd2,
        ON         = 4'd3,
        OFF        = 4'd4,
        KILL       = 4'd5,
        VACUOUSON  = 4'd10,
        VACUOUSOFF = 4'd11
    } actrl_op_e;

    localparam int unsigned N_MAX     = 32;
    localparam int unsigned DELAY_MAX = 8;
    localparam int unsigned CNT_W_MAX = 32;

    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/assert_ctrl_chan.sv
// One monitored channel: a |-> ##DELAY b with enable, lock, vacuous-off
// state and a pending-attempt shift register.
module assert_ctrl_chan
    import assert_ctrl_pkg::*;
#(
    parameter int unsigned DELAY       = 1,
    parameter bit          EN_AT_RESET = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      a,
    input  logic      b,
    input  logic      cmd_hit,
    input  actrl_op_e cmd_op,
    output logic      pass,
    output logic      fail,
    output logic      vac,
    output logic      en,
    output logic      lock
);

    logic             vac_off;
    logic [DELAY:1]   pend;
    logic [DELAY:1]   pend_nxt;
    logic             kill;

    // A kill on an unlocked channel drops both in-flight attempts and a same-edge start.
    assign kill = cmd_hit && (cmd_op == KILL) && !lock;

    always_comb begin
        pend_nxt    = pend << 1;
        pend_nxt[1] = a & en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= EN_AT_RESET;
            lock    <= 1'b0;
            vac_off <= 1'b0;
            pend    <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            vac     <= 1'b0;
        end else begin
            pass <= pend[DELAY] &  b & !kill;
            fail <= pend[DELAY] & !b & !kill;
            vac  <= en & !a & !vac_off;
            pend <= kill ? '0 : pend_nxt;
            if (cmd_hit && (!lock || cmd_op == UNLOCK)) begin
                case (cmd_op)
                    LOCK:       lock    <= 1'b1;
                    UNLOCK:     lock    <= 1'b0;
                    ON:         en      <= 1'b1;
                    OFF:        en      <= 1'b0;
                    VACUOUSON:  vac_off <= 1'b0;
                    VACUOUSOFF: vac_off <= 1'b1;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: rtl/assert_ctrl_mux.sv
// N-channel assertion checker with run-time assertion-control commands.
// Optional vac_cnt output when ASSERT_CTRL_VAC_CNT_EN is defined.
module assert_ctrl_mux
    import assert_ctrl_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned DELAY       = 1,
    parameter int unsigned CNT_W       = 16,
    parameter bit          EN_AT_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [N-1:0]     cmd_mask,
    input  logic             cnt_clr,
    output logic [N-1:0]     pass_o,
    output logic [N-1:0]     fail_o,
    output logic [N-1:0]     vac_o,
    output logic [N-1:0]     en_o,
    output logic [N-1:0]     lock_o,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
`ifdef ASSERT_CTRL_VAC_CNT_EN
    output logic [CNT_W-1:0] vac_cnt,
`endif
    output logic             cmd_err
);

    if (N < 1 || N > N_MAX) begin : g_bad_n
        $error("assert_ctrl_mux: N out of range");
    end
    if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
        $error("assert_ctrl_mux: DELAY out of range");
    end
    if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("assert_ctrl_mux: CNT_W out of range");
    end

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic      cmd_acc;
    logic      op_known;
    actrl_op_e op;

    assign cmd_acc = cmd_valid & cmd_ready;
    assign op      = actrl_op_e'(cmd_op);

    always_comb begin
        op_known = 1'b0;
        case (cmd_op)
            LOCK, UNLOCK, ON, OFF, KILL, VACUOUSON, VACUOUSOFF: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        assert_ctrl_chan #(
            .DELAY       (DELAY),
            .EN_AT_RESET (EN_AT_RESET)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .a       (a[i]),
            .b       (b[i]),
            .cmd_hit (cmd_acc & cmd_mask[i]),
            .cmd_op  (op),
            .pass    (pass_o[i]),
            .fail    (fail_o[i]),
            .vac     (vac_o[i]),
            .en      (en_o[i]),
            .lock    (lock_o[i])
        );
    end

    // Ready drops for the flush cycle that follows any accepted KILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            cmd_err   <= 1'b0;
        end else begin
            cmd_ready <= !(cmd_acc && cmd_op == KILL);
            cmd_err   <= cmd_acc & !op_known;
        end
    end

    function automatic logic [31:0] popcount(input logic [N-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int unsigned k = 0; k < N; k++) c += 32'(v[k]);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pass_cnt <= CNT_W'(sat_add(32'(pass_cnt), popcount(pass_o), CNT_MAX));
            fail_cnt <= CNT_W'(sat_add(32'(fail_cnt), popcount(fail_o), CNT_MAX));
        end
    end

`ifdef ASSERT_CTRL_VAC_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) vac_cnt <= '0;
        else                vac_cnt <= CNT_W'(sat_add(32'(vac_cnt), popcount(vac_o), CNT_MAX));
    end
`endif

endmodule
